usb_wr_packer: RTL and testbench
================================

Name: usb_wr_packer

Overview:
Downstream consumer of the register block's USB write path. It selects one of four sources according to usb_wr_mux:
- 0: CPU register writes (usb_wr_data/be/en)
- 1: INA 8-bit samples
- 2: INB 8-bit samples
- 3: USB loopback words

Byte sources are packed into 32-bit words and buffered in a word FIFO. Words are released to the USB transmit core only when committed, by usb_wr_push or an automatic packet threshold. The block returns usb_wr_fifo_full to the register block.

Parameters:
DEPTH, 512, FIFO depth in 32-bit words (power of two).
PKT_WORDS, 128, uncommitted word count that triggers automatic commit (1..DEPTH).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
usb_wr_mux  in  2  source select (0 regs, 1 INA, 2 INB, 3 loopback)
usb_wr_data  in  32  register-path write word
usb_wr_be  in  4  register-path byte enables
usb_wr_en  in  1  register-path single-cycle write strobe
usb_wr_push  in  1  single-cycle commit/flush strobe
ina_data  in  8  INA sample
ina_valid  in  1  INA sample strobe
inb_data  in  8  INB sample
inb_valid  in  1  INB sample strobe
lb_data  in  32  loopback word
lb_be  in  4  loopback byte enables
lb_valid  in  1  loopback word valid
lb_ready  out  1  loopback accept
usb_wr_fifo_full  out  1  FIFO full (count==DEPTH)
usb_wr_overflow  out  1  sticky: a word or partial word was dropped
m_data  out  32  word to USB transmit core
m_be  out  4  byte enables of m_data
m_valid  out  1  committed word available
m_ready  in  1  USB transmit core accept

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: FIFO empty, all counters 0, byte packer empty, lb_ready=0, usb_wr_fifo_full=0, usb_wr_overflow=0, m_valid=0, m_data=0, m_be=0.
- Reset mid-operation discards all buffered, partial and committed data; no partial word is emitted.
- Source gating: only the selected source is accepted. Strobes from unselected sources are ignored and do not set overflow.
- Regs source (mux 0): each usb_wr_en cycle writes {usb_wr_data, usb_wr_be} as one word. The word is visible in the FIFO next cycle.
- Byte sources (mux 1/2), little-endian packing:
  - The first sample goes to byte 0, and byte_cnt 0..3 increments per valid.
  - On the 4th byte, the word is written with be=4'hF and byte_cnt wraps to 0.
- Loopback (mux 3): lb_ready = (mux==3) && !full. A word transfers when lb_valid && lb_ready. Loopback is never dropped; back-pressure only.
- Flush on push or mux change: if byte_cnt>0 when usb_wr_push pulses or usb_wr_mux changes value, the partial word is written with be set for the filled low bytes, e.g. 2 bytes -> 4'b0011. Unfilled bytes are 0.
- Same-cycle completion and push: if a byte completes a word in the same cycle as a push, that word is written and included in the commit.
- Full FIFO:
  - A regs or byte-path write attempted while full is dropped and sets usb_wr_overflow.
  - A full-word byte path drop clears byte_cnt.
  - usb_wr_overflow clears only on reset.
- Commit counters: uncommitted = words written since the last commit; committed = words released but not yet read.
- Commit events:
  - usb_wr_push moves all uncommitted words to committed, including a flushed partial word written the same cycle.
  - Automatic commit occurs when uncommitted reaches PKT_WORDS.
- m_valid = (committed>0). m_data and m_be come from the FIFO head. A read occurs when m_valid && m_ready, decrementing committed.
- Latency: earliest m_valid is the cycle after the commit event.
- Simultaneous write and read: count is unchanged and full does not toggle.
- Wrap-around: pointers are AW+1 bits, AW=$clog2(DEPTH). full/empty are derived from the MSB difference.
- Invariant: committed + uncommitted == FIFO count.

Decomposition:
- Shared package usb_pkg: USB_SRC_REGS=2'd0, USB_SRC_INA=2'd1, USB_SRC_INB=2'd2, USB_SRC_LOOP=2'd3, plus the usb_word_t struct {data[31:0], be[3:0]}.
- Sub-module usb_word_fifo: synchronous FWFT FIFO of usb_word_t with full/empty/count.
- Packer, mux gating and commit counters stay in usb_wr_packer.

Test Plan:
- mux=0, 3 usb_wr_en writes (0x11111111, 0x22222222, 0x33333333, be=F), m_ready=1 -> m_valid stays 0. Then push -> 3 words out in order, then m_valid=0.
- mux=1, ina bytes 0xA1,0xB2,0xC3,0xD4,0xE5, then push -> words 0xD4C3B2A1 be=F and 0x000000E5 be=4'b0001.
- mux=2, 3 inb bytes, then switch mux to 0 -> partial word with be=4'b0111 written; it is released only after the next push.
- PKT_WORDS=4, DEPTH=8, mux=3, lb_valid held with m_ready=0:
  - auto-commit after the 4th word;
  - lb_ready drops after 8 words and usb_wr_fifo_full=1;
  - usb_wr_overflow stays 0.
- Fill to full with mux=0, then one more usb_wr_en -> word dropped and usb_wr_overflow=1. After push and drain, exactly DEPTH words are read.
- Reset asserted while committed=3 and byte_cnt=2 -> next cycle m_valid=0, overflow=0; subsequent traffic is unaffected.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared source encodings, word payload type and byte-enable helper for the USB write path.
package usb_pkg;

  localparam int unsigned USB_DW  = 32;
  localparam int unsigned USB_BEW = 4;

  localparam logic [1:0] USB_SRC_REGS = 2'd0;
  localparam logic [1:0] USB_SRC_INA  = 2'd1;
  localparam logic [1:0] USB_SRC_INB  = 2'd2;
  localparam logic [1:0] USB_SRC_LOOP = 2'd3;

  typedef struct packed {
    logic [USB_DW-1:0]  data;
    logic [USB_BEW-1:0] be;
  } usb_word_t;

  // Byte enables covering the lowest n bytes of a word.
  function automatic logic [USB_BEW-1:0] usb_be_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/usb_word_fifo.sv
// First-word-fall-through FIFO of usb_word_t; pointers carry one extra wrap bit.
module usb_word_fifo
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  usb_word_t                wr_word,
  input  logic                     rd_en,
  output usb_word_t                rd_word,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_ok, rd_ok;
  usb_word_t   mem [DEPTH];

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_word = mem[rd_ptr_q[AW-1:0]];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_word;
  end

endmodule

// File: rtl/usb_wr_packer.sv
// Selects one USB write source, packs byte streams into words, and releases words
// from the FIFO only once committed by push or the packet-size threshold.
module usb_wr_packer
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned PKT_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  usb_wr_mux,
  input  logic [31:0] usb_wr_data,
  input  logic [3:0]  usb_wr_be,
  input  logic        usb_wr_en,
  input  logic        usb_wr_push,
  input  logic [7:0]  ina_data,
  input  logic        ina_valid,
  input  logic [7:0]  inb_data,
  input  logic        inb_valid,
  input  logic [31:0] lb_data,
  input  logic [3:0]  lb_be,
  input  logic        lb_valid,
  output logic        lb_ready,
  output logic        usb_wr_fifo_full,
  output logic        usb_wr_overflow,
  output logic [31:0] m_data,
  output logic [3:0]  m_be,
  output logic        m_valid,
  input  logic        m_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [1:0]    mux_q, mux_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   pack_q, pack_d;
  logic [CW-1:0] unc_q, unc_d;
  logic [CW-1:0] com_q, com_d;
  logic          overflow_q, overflow_d;
  logic          m_valid_q, m_valid_d;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  usb_word_t     fifo_head;
  usb_word_t     wr_word_c;
  logic          wr_req_c, wr_fire_c, rd_fire_c, flush_old_c, smp_v_c;
  logic [7:0]    smp_c;
  logic [2:0]    cnt_n_c;
  logic [31:0]   acc_c;

  assign smp_v_c     = ((usb_wr_mux == USB_SRC_INA) && ina_valid) ||
                       ((usb_wr_mux == USB_SRC_INB) && inb_valid);
  assign smp_c       = (usb_wr_mux == USB_SRC_INB) ? inb_data : ina_data;
  assign flush_old_c = (usb_wr_mux != mux_q) && (byte_cnt_q != 2'd0);
  // The flush word owns the FIFO write slot this cycle, so loopback is held off.
  assign lb_ready    = !reset && (usb_wr_mux == USB_SRC_LOOP) && !fifo_full && !flush_old_c;
  assign wr_fire_c   = wr_req_c && !fifo_full;
  assign rd_fire_c   = m_valid_q && m_ready;

  always_comb begin
    mux_d      = usb_wr_mux;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    overflow_d = overflow_q;
    wr_req_c   = 1'b0;
    wr_word_c  = '0;
    acc_c      = {8'h00, pack_q};
    cnt_n_c    = {1'b0, byte_cnt_q} + 3'(smp_v_c);
    if (smp_v_c) acc_c[{byte_cnt_q, 3'b000} +: 8] = smp_c;

    if (flush_old_c) begin
      // Old partial leaves first; a new sample restarts packing, a same-cycle reg write is lost.
      wr_req_c       = 1'b1;
      wr_word_c.data = {8'h00, pack_q};
      wr_word_c.be   = usb_be_mask({1'b0, byte_cnt_q});
      byte_cnt_d     = smp_v_c ? 2'd1 : 2'd0;
      pack_d         = {16'h0000, (smp_v_c ? smp_c : 8'h00)};
      if ((usb_wr_mux == USB_SRC_REGS) && usb_wr_en) overflow_d = 1'b1;
    end else begin
      case (usb_wr_mux)
        USB_SRC_REGS: begin
          if (usb_wr_en) begin
            wr_req_c       = 1'b1;
            wr_word_c.data = usb_wr_data;
            wr_word_c.be   = usb_wr_be;
          end
        end
        USB_SRC_LOOP: begin
          if (lb_valid && lb_ready) begin
            wr_req_c       = 1'b1;
            wr_word_c.data = lb_data;
            wr_word_c.be   = lb_be;
          end
        end
        default: begin
          if ((cnt_n_c == 3'd4) || (usb_wr_push && (cnt_n_c != 3'd0))) begin
            wr_req_c       = 1'b1;
            wr_word_c.data = acc_c;
            wr_word_c.be   = usb_be_mask(cnt_n_c);
            byte_cnt_d     = 2'd0;
            pack_d         = '0;
          end else begin
            byte_cnt_d = cnt_n_c[1:0];
            pack_d     = acc_c[23:0];
          end
        end
      endcase
    end

    if (wr_req_c && fifo_full) overflow_d = 1'b1;
  end

  // Commit accounting: words written this cycle join the commit that fires this cycle.
  always_comb begin
    unc_d = unc_q + CW'(wr_fire_c);
    com_d = com_q - CW'(rd_fire_c);
    if (usb_wr_push || (unc_d == CW'(PKT_WORDS))) begin
      com_d = com_d + unc_d;
      unc_d = '0;
    end
    m_valid_d = (com_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mux_q      <= USB_SRC_REGS;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      unc_q      <= '0;
      com_q      <= '0;
      overflow_q <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      mux_q      <= mux_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
      unc_q      <= unc_d;
      com_q      <= com_d;
      overflow_q <= overflow_d;
      m_valid_q  <= m_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((com_q + unc_q) == fifo_count);
      assert (!m_valid_q || !fifo_empty);
    end
  end

  usb_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_fire_c),
    .wr_word (wr_word_c),
    .rd_en   (rd_fire_c),
    .rd_word (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign usb_wr_fifo_full = fifo_full;
  assign usb_wr_overflow  = overflow_q;
  assign m_valid          = m_valid_q;
  assign m_data           = m_valid_q ? fifo_head.data : '0;
  assign m_be             = m_valid_q ? fifo_head.be : '0;

endmodule

// File: tb/tb_usb_wr_packer.sv
// Directed and randomized checks of usb_wr_packer against a queue-based reference model.
module tb_usb_wr_packer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PKT   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  usb_wr_mux;
  logic [31:0] usb_wr_data;
  logic [3:0]  usb_wr_be;
  logic        usb_wr_en, usb_wr_push;
  logic [7:0]  ina_data, inb_data;
  logic        ina_valid, inb_valid;
  logic [31:0] lb_data;
  logic [3:0]  lb_be;
  logic        lb_valid, lb_ready;
  logic        usb_wr_fifo_full, usb_wr_overflow;
  logic [31:0] m_data;
  logic [3:0]  m_be;
  logic        m_valid, m_ready;

  usb_wr_packer #(.DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
    .clk(clk), .reset(reset), .usb_wr_mux(usb_wr_mux), .usb_wr_data(usb_wr_data),
    .usb_wr_be(usb_wr_be), .usb_wr_en(usb_wr_en), .usb_wr_push(usb_wr_push),
    .ina_data(ina_data), .ina_valid(ina_valid), .inb_data(inb_data), .inb_valid(inb_valid),
    .lb_data(lb_data), .lb_be(lb_be), .lb_valid(lb_valid), .lb_ready(lb_ready),
    .usb_wr_fifo_full(usb_wr_fifo_full), .usb_wr_overflow(usb_wr_overflow),
    .m_data(m_data), .m_be(m_be), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored words, commit counts, pending bytes, previous mux, sticky overflow.
  logic [31:0] md_q[$];
  logic [3:0]  mb_q[$];
  logic [7:0]  bq[$];
  int          unc, com;
  logic [1:0]  pmux;
  bit          ovf;
  bit          chk_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_chg();
    return (pmux != usb_wr_mux) && (bq.size() > 0);
  endfunction

  task automatic pack_bytes(output logic [31:0] d, output logic [3:0] b);
    d = '0;
    for (int i = 0; i < bq.size(); i++) d = d | (32'(bq[i]) << (8 * i));
    b = 4'((1 << bq.size()) - 1);
  endtask

  task automatic check_outputs();
    bit mv, full;
    mv   = (com > 0);
    full = (md_q.size() == DEPTH);
    check("m_valid", 32'(m_valid), 32'(mv));
    check("m_data", m_data, mv ? md_q[0] : 32'h0);
    check("m_be", 32'(m_be), mv ? 32'(mb_q[0]) : 32'h0);
    check("fifo_full", 32'(usb_wr_fifo_full), 32'(full));
    check("lb_ready", 32'(lb_ready),
          32'(!reset && (usb_wr_mux == 2'd3) && !full && !model_chg()));
    check("overflow", 32'(usb_wr_overflow), 32'(ovf));
  endtask

  task automatic model_update();
    logic [31:0] d;
    logic [3:0]  b;
    bit have, full, chg, rd, lbr, wrote;
    if (reset) begin
      md_q.delete(); mb_q.delete(); bq.delete();
      unc = 0; com = 0; ovf = 0; pmux = 2'd0;
      return;
    end
    full = (md_q.size() == DEPTH);
    chg  = model_chg();
    rd   = (com > 0) && m_ready;
    lbr  = (usb_wr_mux == 2'd3) && !full && !chg;
    have = 0; wrote = 0; d = '0; b = '0;
    if (chg) begin
      pack_bytes(d, b);
      have = 1;
      bq.delete();
      if (usb_wr_mux == 2'd1 && ina_valid) bq.push_back(ina_data);
      if (usb_wr_mux == 2'd2 && inb_valid) bq.push_back(inb_data);
      if (usb_wr_mux == 2'd0 && usb_wr_en) ovf = 1;
    end else begin
      case (usb_wr_mux)
        2'd0: if (usb_wr_en) begin have = 1; d = usb_wr_data; b = usb_wr_be; end
        2'd3: if (lb_valid && lbr) begin have = 1; d = lb_data; b = lb_be; end
        default: begin
          if (usb_wr_mux == 2'd1 && ina_valid) bq.push_back(ina_data);
          if (usb_wr_mux == 2'd2 && inb_valid) bq.push_back(inb_data);
          if (bq.size() == 4 || (usb_wr_push && bq.size() > 0)) begin
            pack_bytes(d, b);
            have = 1;
            bq.delete();
          end
        end
      endcase
    end
    if (have) begin
      if (full) ovf = 1;
      else begin md_q.push_back(d); mb_q.push_back(b); wrote = 1; end
    end
    if (rd) begin void'(md_q.pop_front()); void'(mb_q.pop_front()); com--; end
    unc += int'(wrote);
    if (usb_wr_push || unc == PKT) begin com += unc; unc = 0; end
    pmux = usb_wr_mux;
  endtask

  // One clock: check outputs mid-low-phase, advance the model at the edge.
  task automatic cyc();
    #1;
    if (chk_en) check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] d, input logic [3:0] b);
    check({tag, "_valid"}, 32'(m_valid), 32'h1);
    check({tag, "_data"}, m_data, d);
    check({tag, "_be"}, 32'(m_be), 32'(b));
  endtask

  initial begin
    logic [7:0] ina_seq [5];
    int reads;
    ina_seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    reset = 1; usb_wr_mux = 0; usb_wr_data = 0; usb_wr_be = 0; usb_wr_en = 0; usb_wr_push = 0;
    ina_data = 0; ina_valid = 0; inb_data = 0; inb_valid = 0;
    lb_data = 0; lb_be = 0; lb_valid = 0; m_ready = 0; chk_en = 0;
    @(negedge clk);
    cyc(); cyc();
    reset = 0; chk_en = 1;
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_be", 32'(m_be), 32'h0);
    check("rst_full", 32'(usb_wr_fifo_full), 32'h0);
    check("rst_overflow", 32'(usb_wr_overflow), 32'h0);
    check("rst_lb_ready", 32'(lb_ready), 32'h0);

    // Register writes held until push.
    usb_wr_mux = 0; m_ready = 1; usb_wr_be = 4'hF; usb_wr_en = 1;
    usb_wr_data = 32'h11111111; cyc();
    usb_wr_data = 32'h22222222; cyc();
    usb_wr_data = 32'h33333333; cyc();
    usb_wr_en = 0; cyc(); cyc();
    check("regs_uncommitted", 32'(m_valid), 32'h0);
    usb_wr_push = 1; cyc(); usb_wr_push = 0;
    expect_head("regs0", 32'h11111111, 4'hF); cyc();
    expect_head("regs1", 32'h22222222, 4'hF); cyc();
    expect_head("regs2", 32'h33333333, 4'hF); cyc();
    check("regs_drained", 32'(m_valid), 32'h0);

    // INA byte packing with partial flush on push.
    usb_wr_mux = 1; ina_valid = 1;
    for (int i = 0; i < 5; i++) begin ina_data = ina_seq[i]; cyc(); end
    ina_valid = 0; usb_wr_push = 1; cyc(); usb_wr_push = 0;
    expect_head("ina_full", 32'hD4C3B2A1, 4'hF); cyc();
    expect_head("ina_part", 32'h000000E5, 4'b0001); cyc();
    check("ina_drained", 32'(m_valid), 32'h0);

    // INB partial flushed by mux change, released by the later push.
    usb_wr_mux = 2; inb_valid = 1;
    inb_data = 8'h11; cyc(); inb_data = 8'h22; cyc(); inb_data = 8'h33; cyc();
    inb_valid = 0; usb_wr_mux = 0; cyc(); cyc();
    check("inb_held", 32'(m_valid), 32'h0);
    usb_wr_push = 1; cyc(); usb_wr_push = 0;
    expect_head("inb_part", 32'h00332211, 4'b0111); cyc();
    check("inb_drained", 32'(m_valid), 32'h0);

    // Loopback back-pressure with auto-commit.
    m_ready = 0; usb_wr_mux = 3; lb_valid = 1; lb_be = 4'hF;
    for (int i = 0; i < 12; i++) begin
      lb_data = 32'hC000_0000 + 32'(i);
      if (i == 3) check("lb_pre_commit", 32'(m_valid), 32'h0);
      if (i == 4) check("lb_auto_commit", 32'(m_valid), 32'h1);
      cyc();
    end
    check("lb_full", 32'(usb_wr_fifo_full), 32'h1);
    check("lb_ready_low", 32'(lb_ready), 32'h0);
    check("lb_no_overflow", 32'(usb_wr_overflow), 32'h0);
    check("lb_head", m_data, 32'hC000_0000);
    lb_valid = 0; m_ready = 1;
    for (int i = 0; i < 10; i++) cyc();
    check("lb_drained", 32'(m_valid), 32'h0);

    // Register overflow when full, then drain exactly DEPTH words.
    usb_wr_mux = 0; m_ready = 0; usb_wr_en = 1; usb_wr_be = 4'hF;
    for (int i = 0; i < 9; i++) begin usb_wr_data = 32'hA000_0000 + 32'(i); cyc(); end
    usb_wr_en = 0;
    check("ovf_set", 32'(usb_wr_overflow), 32'h1);
    check("ovf_full", 32'(usb_wr_fifo_full), 32'h1);
    usb_wr_push = 1; cyc(); usb_wr_push = 0; m_ready = 1;
    reads = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid) reads++;
      cyc();
    end
    check("ovf_drain_count", 32'(reads), 32'(DEPTH));

    // Reset with committed words and a partial byte word pending.
    m_ready = 0; usb_wr_en = 1;
    for (int i = 0; i < 3; i++) begin usb_wr_data = 32'h5A00_0000 + 32'(i); cyc(); end
    usb_wr_en = 0; usb_wr_push = 1; cyc(); usb_wr_push = 0;
    usb_wr_mux = 1; ina_valid = 1; ina_data = 8'h77; cyc(); ina_data = 8'h88; cyc();
    ina_valid = 0; reset = 1; cyc(); reset = 0;
    check("mid_rst_m_valid", 32'(m_valid), 32'h0);
    check("mid_rst_overflow", 32'(usb_wr_overflow), 32'h0);
    check("mid_rst_full", 32'(usb_wr_fifo_full), 32'h0);
    usb_wr_mux = 0; usb_wr_en = 1; usb_wr_data = 32'hCAFEF00D; usb_wr_be = 4'b1010;
    usb_wr_push = 1; m_ready = 1; cyc();
    usb_wr_en = 0; usb_wr_push = 0;
    expect_head("post_rst", 32'hCAFEF00D, 4'b1010); cyc();
    check("post_rst_drained", 32'(m_valid), 32'h0);

    // Randomized traffic across all sources.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) usb_wr_mux = 2'($urandom_range(0, 3));
      usb_wr_en   = ($urandom_range(0, 2) == 0);
      usb_wr_data = $urandom;
      usb_wr_be   = 4'($urandom);
      ina_valid   = 1'($urandom_range(0, 1));
      ina_data    = 8'($urandom);
      inb_valid   = 1'($urandom_range(0, 1));
      inb_data    = 8'($urandom);
      lb_valid    = 1'($urandom_range(0, 1));
      lb_data     = $urandom;
      lb_be       = 4'($urandom);
      usb_wr_push = ($urandom_range(0, 9) == 0);
      m_ready     = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset = 0; usb_wr_en = 0; ina_valid = 0; inb_valid = 0; lb_valid = 0; usb_wr_push = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
